// File: rtl/sumador_serie.sv
// rtl/sumador_serie.sv - bit-serial adder, LSB first, one bit per clock.
// Optional signed-overflow port enabled by `define SUMADOR_SERIE_DESBORDE_EN.
module sumador_serie #(
  parameter int ANCHO = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inicio,
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  output logic             ocupado,
  output logic             listo,
  output logic [ANCHO-1:0] suma,
  output logic             acarreo
`ifdef SUMADOR_SERIE_DESBORDE_EN
  ,
  output logic             desborde
`endif
);

  localparam int CW = (ANCHO > 2) ? $clog2(ANCHO) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(ANCHO - 1);

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    SUMA   = 2'd1,
    FIN    = 2'd2
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [ANCHO-1:0] a_q, a_d;
  logic [ANCHO-1:0] b_q, b_d;
  logic [ANCHO-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ANCHO-1:0] suma_q, suma_d;
  logic             acarreo_q, acarreo_d;
  logic             listo_q, listo_d;

  // Full-adder bit cell working on the current LSBs of the operand shifters
  logic bit_s;
  logic bit_c;
  assign bit_s = a_q[0] ^ b_q[0] ^ carry_q;
  assign bit_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

`ifdef SUMADOR_SERIE_DESBORDE_EN
  // Carry into the MSB is kept so overflow can be formed once the carry-out is known
  logic c_msb_q, c_msb_d;
  logic desborde_q, desborde_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q   <= REPOSO;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      suma_q     <= '0;
      acarreo_q  <= 1'b0;
      listo_q    <= 1'b0;
`ifdef SUMADOR_SERIE_DESBORDE_EN
      c_msb_q    <= 1'b0;
      desborde_q <= 1'b0;
`endif
    end else begin
      estado_q   <= estado_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      suma_q     <= suma_d;
      acarreo_q  <= acarreo_d;
      listo_q    <= listo_d;
`ifdef SUMADOR_SERIE_DESBORDE_EN
      c_msb_q    <= c_msb_d;
      desborde_q <= desborde_d;
`endif
    end
  end

  always_comb begin
    estado_d   = estado_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    suma_d     = suma_q;
    acarreo_d  = acarreo_q;
    listo_d    = 1'b0;
`ifdef SUMADOR_SERIE_DESBORDE_EN
    c_msb_d    = c_msb_q;
    desborde_d = desborde_q;
`endif

    case (estado_q)
      REPOSO: begin
        if (inicio) begin
          a_d      = a;
          b_d      = b;
          res_d    = '0;
          carry_d  = 1'b0;
          cnt_d    = '0;
          estado_d = SUMA;
        end
      end

      SUMA: begin
        res_d   = {bit_s, res_q[ANCHO-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = bit_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == ULTIMO) begin
          estado_d = FIN;
`ifdef SUMADOR_SERIE_DESBORDE_EN
          c_msb_d  = carry_q;
`endif
        end
      end

      FIN: begin
        suma_d     = res_q;
        acarreo_d  = carry_q;
        listo_d    = 1'b1;
`ifdef SUMADOR_SERIE_DESBORDE_EN
        desborde_d = c_msb_q ^ carry_q;
`endif
        estado_d   = REPOSO;
      end

      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  assign ocupado = (estado_q != REPOSO);
  assign listo   = listo_q;
  assign suma    = suma_q;
  assign acarreo = acarreo_q;
`ifdef SUMADOR_SERIE_DESBORDE_EN
  assign desborde = desborde_q;
`endif

endmodule

// File: doc/sumador_serie.md
SUMADOR_SERIE -- requirements
Module: sumador_serie

Interface
REQ-001 The block SHALL have parameter ANCHO, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 The block SHALL have port inicio  input  1  start request; sampled only in state REPOSO.
REQ-005 The block SHALL have port a  input  ANCHO  first operand; captured on accepted start.
REQ-006 The block SHALL have port b  input  ANCHO  second operand; captured on accepted start.
REQ-007 The block SHALL have port ocupado  output  1  high while an addition is in progress.
REQ-008 The block SHALL have port listo  output  1  one-cycle pulse when suma/acarreo become valid.
REQ-009 The block SHALL have port suma  output  ANCHO  registered sum a+b modulo 2^ANCHO.
REQ-010 The block SHALL have port acarreo  output  1  registered carry-out of the unsigned addition.

Function
REQ-011 The block SHALL add bit-serially, LSB first, one bit per clock, using a bit cell: s = ai^bi^c, c' = (ai&bi)|(c&(ai^bi)).
REQ-012 The FSM SHALL have states REPOSO, SUMA and FIN, in addition to reset.
REQ-013 In REPOSO with inicio=1, the block SHALL capture a and b into shift registers, clear the carry register and the bit counter, and go to SUMA.
REQ-014 In REPOSO with inicio=0, the block SHALL stay in REPOSO and hold suma, acarreo and all internal state.
REQ-015 In SUMA, each cycle SHALL shift one result bit into the result shift register MSB-ward, update the carry register and increment the counter.
REQ-016 SUMA SHALL last exactly ANCHO cycles; after the cycle that processes bit ANCHO-1, the FSM SHALL go to FIN.
REQ-017 In FIN, suma and acarreo SHALL load from the result and carry registers, listo SHALL be 1 for that cycle only, and the FSM SHALL go to REPOSO.
REQ-018 Latency: for inicio accepted at edge T, listo SHALL be high in the cycle after edge T+ANCHO+1, and a new inicio SHALL be accepted no earlier than edge T+ANCHO+2.
REQ-019 ocupado SHALL be 1 in SUMA and FIN, and 0 in REPOSO.
REQ-020 inicio SHALL be ignored while ocupado=1, with no queuing, and a and b SHALL NOT be re-sampled.
REQ-021 suma and acarreo SHALL hold their last values until the next FIN; they SHALL NOT change in SUMA.
REQ-022 Wrap-around: when the sum is 2^ANCHO or more, suma SHALL be the low ANCHO bits and acarreo SHALL be 1.
REQ-023 inicio held high continuously SHALL start back-to-back operations, each accepted on the first REPOSO cycle.

Reset
REQ-024 With rst_n=0 at a rising edge, the block SHALL enter REPOSO with ocupado=0, listo=0, suma=0, acarreo=0, and the counter, carry and shift registers cleared.
REQ-025 Reset during SUMA or FIN SHALL abort the operation, SHALL NOT pulse listo, and SHALL clear suma and acarreo.
REQ-026 inicio SHALL be ignored in any cycle in which rst_n=0.

Configuration
REQ-027 When macro SUMADOR_SERIE_DESBORDE_EN is defined, the block SHALL add port desborde (output, 1 bit, reset 0), the signed two's-complement overflow, equal to the carry into bit ANCHO-1 XOR the carry out of bit ANCHO-1.
REQ-028 When SUMADOR_SERIE_DESBORDE_EN is defined, desborde SHALL be registered in FIN alongside suma and held until the next FIN.
REQ-029 When SUMADOR_SERIE_DESBORDE_EN is undefined, the desborde port and its logic SHALL be absent, with all other behaviour identical.

Verification (ANCHO=8)
REQ-030 The bench SHALL check: reset, then a=0x0F, b=0x01, inicio pulse -> ocupado high for 9 cycles, listo once, suma=0x10, acarreo=0.
REQ-031 The bench SHALL check: a=0xFF, b=0x01 -> suma=0x00, acarreo=1 (desborde=0 when enabled).
REQ-032 The bench SHALL check: a=0x7F, b=0x01 -> suma=0x80, acarreo=0 (desborde=1 when enabled); a=0x80, b=0x80 -> suma=0x00, acarreo=1 (desborde=1 when enabled).
REQ-033 The bench SHALL check: a second inicio with new a/b while ocupado=1 -> ignored, and the result equals the first operands' sum.
REQ-034 The bench SHALL check: rst_n=0 on the 4th SUMA cycle -> no listo, suma=0, acarreo=0, ocupado=0, and the next operation 0x55+0xAA gives suma=0xFF, acarreo=0.
REQ-035 The bench SHALL check: inicio held high for 3 operations -> 3 listo pulses spaced exactly ANCHO+2 cycles apart.
